// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Holds the FSM encoding, default widths and the divide-by-zero quotient value.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;
  localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W + 1);

  localparam logic [DEF_DIVIDEND_W-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; no latency, no flow control.
module div_restore_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 qbit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+2:0] trial;

  assign shifted = {prem, din};
  assign trial   = {1'b0, shifted} - {3'b000, divisor};

  // prem < divisor on entry, so a non-negative trial always fits back in DIVISOR_W+1 bits.
  assign qbit      = (trial[DIVISOR_W+2:DIVISOR_W+1] == 2'b00);
  assign prem_next = qbit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Latency DIVIDEND_W cycles (1 for divide by zero); start ignored while busy, accepted in DONE.
module seq_divider_8by4
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [DIVIDEND_W-1:0]  dq_q;
  logic [DIVISOR_W-1:0]   dsr_q;
  logic [DIVISOR_W:0]     prem_q;
  logic [DIVISOR_W:0]     prem_next;
  logic                   qbit;

  // dq_q shifts dividend bits out of the top and quotient bits in at the bottom,
  // so after DIVIDEND_W steps it holds the full quotient.
  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem      (prem_q),
    .din       (dq_q[DIVIDEND_W-1]),
    .divisor   (dsr_q),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq_q        <= '0;
      dsr_q       <= '0;
      prem_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dq_q        <= dividend;
            dsr_q       <= divisor;
            prem_q      <= '0;
            div_by_zero <= 1'b0;
            state       <= RUN;
            // A zero count marks the single non-busy cycle of a divide by zero.
            if (divisor == '0) begin
              cnt  <= '0;
              busy <= 1'b0;
            end else begin
              cnt  <= CNT_W'(DIVIDEND_W);
              busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            quotient    <= {DIVIDEND_W{DZ_QUOTIENT[0]}};
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            dq_q   <= {dq_q[DIVIDEND_W-2:0], qbit};
            prem_q <= prem_next;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              quotient  <= {dq_q[DIVIDEND_W-2:0], qbit};
              remainder <= prem_next[DIVISOR_W-1:0];
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4 against a plain-arithmetic divide model.
// Directed cases, ignored-start, mid-run reset, random ops with gaps, exhaustive back-to-back.
module tb_seq_divider_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned last_q = 0;
  int unsigned last_r = 0;

  seq_divider_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one division after 'gap' idle cycles and check handshake timing and results.
  task automatic run_op(input int unsigned a, input int unsigned b, input int gap);
    int unsigned eq, er, edz, elat;
    int cyc;
    bit busy_bad;
    if (b == 0) begin
      eq = 255; er = 0; edz = 1; elat = 1;
    end else begin
      eq = a / b; er = a % b; edz = 0; elat = 8;
    end
    if (gap > 0) begin
      tick;
      chk("done_drop", done, 0);
      chk("hold_q", quotient, last_q);
      chk("hold_r", remainder, last_r);
      repeat (gap - 1) tick;
    end
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_at_accept", busy, (b != 0) ? 1 : 0);
    cyc = 0;
    busy_bad = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      if (done !== 1'b1 && busy !== (b != 0)) busy_bad = 1'b1;
    end
    chk("latency", cyc, elat);
    chk("busy_profile", busy_bad, 0);
    chk("busy_at_done", busy, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int cyc;
    int dones;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    tick;
    chk("idle_done", done, 0);

    run_op(143, 11, 0);
    run_op(200, 7, 1);
    run_op(225, 15, 2);
    run_op(5, 9, 1);
    run_op(77, 0, 1);
    run_op(77, 7, 0);

    // A start raised mid-run with changing operands must be ignored.
    dividend = 8'd143;
    divisor  = 4'd11;
    start    = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick;
      cyc++;
      if (cyc == 3) begin
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 4'd1;
      end else if (cyc > 3) begin
        dividend = ~dividend;
        divisor  = ~divisor;
      end
      if (cyc >= 6) start = 1'b0;
    end
    chk("ign_latency", cyc, 8);
    chk("ign_q", quotient, 13);
    chk("ign_r", remainder, 0);
    dones = 0;
    repeat (12) begin
      tick;
      if (done === 1'b1) dones++;
    end
    chk("ign_no_second_done", dones, 0);

    // Reset in the middle of a run abandons it with no done pulse.
    dividend = 8'd250;
    divisor  = 4'd6;
    start    = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_dz", div_by_zero, 0);
    dones = 0;
    repeat (12) begin
      tick;
      if (done === 1'b1) dones++;
    end
    chk("mrst_no_done", dones, 0);
    last_q = 0;
    last_r = 0;
    run_op(100, 3, 0);

    repeat (300) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 2));
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(a, b, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
